coder_seq: RTL and testbench

Parametrised successor to the coder memory block. It holds a writable table of `DEPTH` code words of `DATA_W` bits and plays a programmed-length prefix of that table out on a valid/ready stream. It runs either once (one-shot) or continuously (loop), and supports pause, abort and runtime table loading. It sits between the control logic, which loads and starts it, and the downstream serializer/encoder that consumes `o_data`.

---
 rtl/coder_seq.sv | 136 +++++++++++++
 tb/tb_coder_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coder_seq.sv
// rtl/coder_seq.sv - programmable code-word table played out on a valid/ready stream
module coder_seq #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_mode,
   input  logic [ADDR_W:0]   i_len,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_wrap
);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              wrap_q, wrap_d;

   logic              acc;
   logic [ADDR_W-1:0] ptr_inc;
   logic [ADDR_W-1:0] len_last;

   assign acc     = valid_q & i_ready & i_enable;
   assign ptr_inc = ptr_q + 1'b1;

   // Index of the final word: length 0 and oversize lengths both mean the full table
   assign len_last = ((i_len == '0) || (i_len > DEPTH_L)) ? ADDR_W'(DEPTH - 1)
                                                           : ADDR_W'(i_len - 1'b1);

   // Table write port; not reset so contents survive i_rst. Reads elsewhere see the old word.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   // Sequencer state and registered stream outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         last_q  <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         last_q  <= last_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   // Next-state: stop beats accept and start; a word is only replaced once accepted
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      last_d  = last_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start && i_enable && !i_stop) begin
               state_d = S_RUN;
               mode_d  = i_mode;
               last_d  = len_last;
               ptr_d   = '0;
               data_d  = mem_q[0];
               valid_d = 1'b1;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end else if (acc) begin
               if (ptr_q != last_q) begin
                  ptr_d  = ptr_inc;
                  data_d = mem_q[ptr_inc];
               end else if (mode_q) begin
                  ptr_d  = '0;
                  data_d = mem_q[0];
                  wrap_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_addr  = ptr_q;
   assign o_busy  = (state_q == S_RUN);
   assign o_done  = done_q;
   assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_coder_seq.sv
// tb/tb_coder_seq.sv - self-checking bench for coder_seq against a word-level reference model
module tb_coder_seq;
   localparam int DW    = 20;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          i_clk = 1'b0;
   logic          i_rst, i_enable, i_start, i_stop, i_mode, i_wr_en, i_ready;
   logic [AW:0]   i_len;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic [DW-1:0] o_data;
   logic          o_valid, o_busy, o_done, o_wrap;
   logic [AW-1:0] o_addr;

   always #5 i_clk = ~i_clk;

   coder_seq #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_start(i_start),
      .i_stop(i_stop), .i_mode(i_mode), .i_len(i_len), .i_wr_en(i_wr_en),
      .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_ready(i_ready),
      .o_data(o_data), .o_valid(o_valid), .o_addr(o_addr), .o_busy(o_busy),
      .o_done(o_done), .o_wrap(o_wrap)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: playing position, effective length, mode and the table
   int m_mem [DEPTH];
   bit m_run, m_loop, m_done, m_wrap, m_after_rst;
   int m_idx, m_len, m_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_update();
      m_done = 0;
      m_wrap = 0;
      m_after_rst = 0;
      if (i_rst) begin
         m_run = 0; m_idx = 0; m_data = 0; m_after_rst = 1;
      end else if (m_run) begin
         if (i_stop) begin
            m_run = 0;
         end else if (i_enable && i_ready) begin
            if (m_idx == m_len - 1) begin
               if (m_loop) begin
                  m_idx = 0; m_data = m_mem[0]; m_wrap = 1;
               end else begin
                  m_run = 0; m_done = 1;
               end
            end else begin
               m_idx = m_idx + 1;
               m_data = m_mem[m_idx];
            end
         end
      end else if (i_start && i_enable && !i_stop) begin
         m_len  = (i_len == 0 || int'(i_len) > DEPTH) ? DEPTH : int'(i_len);
         m_loop = i_mode;
         m_idx  = 0;
         m_data = m_mem[0];
         m_run  = 1;
      end
      // table update after the read so a same-cycle write is seen only on the next pass
      if (i_wr_en) m_mem[i_wr_addr] = int'(i_wr_data);
   endtask

   task automatic step();
      model_update();
      @(posedge i_clk);
      #1;
      check("valid", o_valid, m_run);
      check("busy", o_busy, m_run);
      check("done", o_done, m_done);
      check("wrap", o_wrap, m_wrap);
      if (m_run || m_after_rst) begin
         check("data", o_data, m_data);
         check("addr", o_addr, m_idx);
      end
   endtask

   task automatic idle_in();
      i_rst = 0; i_enable = 1; i_start = 0; i_stop = 0; i_mode = 0; i_len = '0;
      i_wr_en = 0; i_wr_addr = '0; i_wr_data = '0; i_ready = 1;
   endtask

   task automatic start(input int len, input bit mode);
      i_len = (AW+1)'(len); i_mode = mode; i_start = 1;
      step();
      i_start = 0;
   endtask

   task automatic play_len(input int len, input int exp_n, input string tag);
      int n;
      n = 0;
      start(len, 0);
      for (int c = 0; c < 40 && o_valid; c++) begin
         n++;
         step();
      end
      check(tag, n, exp_n);
      check({tag, "_done"}, o_done, 1);
   endtask

   initial begin
      int s, prev;
      bit rdy;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = 0;
      m_run = 0; m_idx = 0; m_len = DEPTH; m_loop = 0; m_data = 0;
      idle_in();
      i_rst = 1;
      step();
      step();
      check("rst_data", o_data, 0);
      check("rst_valid", o_valid, 0);
      i_rst = 0;

      for (int k = 0; k < DEPTH; k++) begin
         i_wr_en = 1; i_wr_addr = AW'(k); i_wr_data = DW'(32'h10000 + k);
         step();
      end
      i_wr_en = 0;
      i_rst = 1; step(); i_rst = 0;

      // one-shot, length 4
      start(4, 0);
      for (int k = 0; k < 4; k++) begin
         check("os_data", o_data, 32'h10000 + k);
         check("os_valid", o_valid, 1);
         step();
      end
      check("os_done", o_done, 1);
      step();
      check("os_done_once", o_done, 0);
      check("os_idle", o_valid, 0);

      // loop, length 3, toggling ready
      start(3, 1);
      s = 0;
      for (int c = 0; c < 14; c++) begin
         rdy = (c % 2 == 0);
         i_ready = rdy;
         check("lp_data", o_data, 32'h10000 + s);
         prev = s;
         step();
         if (rdy) begin
            check("lp_wrap", o_wrap, prev == 2);
            s = (s + 1) % 3;
         end
      end

      // pause for 5 cycles with ready high
      i_ready = 1; i_enable = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         check("pause_data", o_data, 32'h10000 + s);
         check("pause_addr", o_addr, s);
      end
      i_enable = 1;
      step();
      s = (s + 1) % 3;
      check("resume_data", o_data, 32'h10000 + s);

      // start during RUN is ignored, then stop (with start) aborts with no done
      start(1, 0);
      check("run_start_ign", o_busy, 1);
      i_stop = 1; i_start = 1;
      step();
      check("stop_valid", o_valid, 0);
      check("stop_busy", o_busy, 0);
      check("stop_done", o_done, 0);
      step();
      check("stop_prio", o_busy, 0);
      i_stop = 0; i_start = 0;

      // length edges
      play_len(0, 16, "len0");
      step();
      play_len(20, 16, "len20");
      step();
      start(1, 1);
      for (int c = 0; c < 4; c++) begin
         check("len1_data", o_data, 32'h10000);
         step();
         check("len1_wrap", o_wrap, 1);
      end
      i_stop = 1; step(); i_stop = 0;

      // write collision on the word being loaded
      start(4, 1);
      i_wr_en = 1; i_wr_addr = 4'd1; i_wr_data = 20'hABCDE;
      step();
      i_wr_en = 0;
      check("col_old", o_data, 32'h10001);
      for (int c = 0; c < 4; c++) step();
      check("col_new", o_data, 32'hABCDE);
      i_stop = 1; step(); i_stop = 0;
      i_wr_en = 1; i_wr_addr = 4'd1; i_wr_data = 20'h10001;
      step();
      i_wr_en = 0;

      // reset mid-run
      start(16, 0);
      step(); step();
      i_rst = 1;
      step();
      i_rst = 0;
      check("mr_valid", o_valid, 0);
      check("mr_busy", o_busy, 0);
      check("mr_data", o_data, 0);
      check("mr_addr", o_addr, 0);
      check("mr_done", o_done, 0);
      start(4, 0);
      for (int k = 0; k < 4; k++) begin
         check("mr_table", o_data, 32'h10000 + k);
         step();
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         i_rst     = ($urandom_range(0, 299) == 0);
         i_stop    = ($urandom_range(0, 49) == 0);
         i_start   = ($urandom_range(0, 5) == 0);
         i_enable  = ($urandom_range(0, 9) != 0);
         i_ready   = ($urandom_range(0, 9) < 7);
         i_mode    = $urandom_range(0, 1);
         i_len     = (AW+1)'($urandom_range(0, 31));
         i_wr_en   = ($urandom_range(0, 7) == 0);
         i_wr_addr = AW'($urandom_range(0, DEPTH - 1));
         i_wr_data = DW'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
